// File: rtl/cpu_ctrl_mc_if.sv
// cpu_ctrl_mc_if: ready-handshaked memory port between the control unit (master) and BRAM port A (slave).
interface cpu_ctrl_mc_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ready;
   logic [DATA_W-1:0] mem_rdata;
   modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_ready, mem_rdata);
   modport slave (input mem_req, mem_we, mem_addr, mem_wdata, output mem_ready, mem_rdata);
endinterface

// File: rtl/cpu_ctrl_mc.sv
// cpu_ctrl_mc: multicycle fetch/decode/execute sequencer with PC, IR, MDR and load/store/branch control.
// Optional halt on instruction 16'hFFFF enabled by defining CPU_CTRL_HALT_EN.
module cpu_ctrl_mc #(
   parameter int                DATA_W   = 16,
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   cpu_ctrl_mc_if.master     mem,
   input  logic [DATA_W-1:0] rsrc_val,
   input  logic [DATA_W-1:0] rdest_val,
   input  logic [4:0]        flags,
   output logic [15:0]       instr,
   output logic [DATA_W-1:0] mdr,
   output logic              rf_we,
   output logic              wb_sel_mem,
   output logic              flags_we,
   output logic [ADDR_W-1:0] pc,
   output logic [2:0]        state
`ifdef CPU_CTRL_HALT_EN
   ,
   output logic              halted
`endif
);
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] FETCH  = 3'd1;
   localparam logic [2:0] DECODE = 3'd2;
   localparam logic [2:0] EXEC   = 3'd3;
   localparam logic [2:0] MEM    = 3'd4;
   localparam logic [2:0] WB     = 3'd5;
   localparam logic [2:0] BRANCH = 3'd6;
   localparam logic [2:0] HALT   = 3'd7;

   logic [3:0]        op, cond, ext;
   logic              n, z, f, l, c;
   logic              is_load, is_stor, is_jcond, is_bcond, is_cmp, is_halt, taken;
   logic [15:0]       cond_tbl;
   logic [2:0]        state_nxt;
   logic [ADDR_W-1:0] target;

   assign op   = instr[15:12];
   assign cond = instr[11:8];
   assign ext  = instr[7:4];
   assign {n, z, f, l, c} = flags;

   // Indexed by the cond field: bit k is the truth of condition code k.
   assign cond_tbl = {1'b0, 1'b1, n | z, !n & !z, l | z, !l & !z, !f, f,
                      !n, n, !l, l, !c, c, !z, z};

   always_comb begin
      is_load  = op == 4'h4 && ext == 4'h0;
      is_stor  = op == 4'h4 && ext == 4'h4;
      is_jcond = op == 4'h4 && ext == 4'hC;
      is_bcond = op == 4'hC;
      is_cmp   = (op == 4'h0 && ext == 4'hB) || op == 4'hB;
`ifdef CPU_CTRL_HALT_EN
      is_halt  = instr == 16'hFFFF;
`else
      is_halt  = 1'b0;
`endif
      taken    = cond_tbl[cond];
      target   = is_bcond ? pc - ADDR_W'(1) + {{(ADDR_W-8){instr[7]}}, instr[7:0]}
                          : rsrc_val[ADDR_W-1:0];
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:   state_nxt = FETCH;
         FETCH:  state_nxt = mem.mem_ready ? DECODE : FETCH;
         DECODE: state_nxt = is_halt ? HALT
                           : (is_load || is_stor) ? MEM
                           : (is_bcond || is_jcond) ? BRANCH : EXEC;
         EXEC:   state_nxt = FETCH;
         MEM:    state_nxt = !mem.mem_ready ? MEM : is_load ? WB : FETCH;
         WB:     state_nxt = FETCH;
         BRANCH: state_nxt = FETCH;
         HALT:   state_nxt = HALT;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         pc    <= RESET_PC;
         instr <= '0;
         mdr   <= '0;
      end else begin
         state <= state_nxt;
         if (state == FETCH && mem.mem_ready) begin
            instr <= mem.mem_rdata[15:0];
            pc    <= pc + ADDR_W'(1);
         end
         if (state == MEM && mem.mem_ready && is_load) mdr <= mem.mem_rdata;
         if (state == BRANCH && taken) pc <= target;
      end
   end

   // Address and store data are pure functions of state, pc and the IR-selected registers,
   // so they hold steady for the whole wait period.
   assign mem.mem_req   = state == FETCH || state == MEM;
   assign mem.mem_we    = state == MEM && is_stor;
   assign mem.mem_addr  = state == MEM ? rsrc_val[ADDR_W-1:0] : pc;
   assign mem.mem_wdata = rdest_val;
   assign rf_we         = (state == EXEC && !is_cmp) || state == WB;
   assign flags_we      = state == EXEC;
   assign wb_sel_mem    = state == WB;
`ifdef CPU_CTRL_HALT_EN
   assign halted        = state == HALT;
`endif
endmodule

// File: tb/tb_cpu_ctrl_mc.sv
// tb_cpu_ctrl_mc: directed checks of the multicycle control unit, plus a RESET_PC=FFFF instance for PC wrap.
module tb_cpu_ctrl_mc;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] rsrc_val, rdest_val;
   logic [4:0]  flags;
   logic [15:0] instr, mdr, pc;
   logic        rf_we, wb_sel_mem, flags_we;
   logic [2:0]  state;
   logic [15:0] w_instr, w_mdr, w_pc;
   logic        w_rf_we, w_wb_sel_mem, w_flags_we;
   logic [2:0]  w_state;
`ifdef CPU_CTRL_HALT_EN
   logic        halted, w_halted;
`endif
   int vectors = 0;
   int miscompares = 0;

   cpu_ctrl_mc_if #(.DATA_W(16), .ADDR_W(16)) bus ();
   cpu_ctrl_mc_if #(.DATA_W(16), .ADDR_W(16)) bus_w ();

   assign bus_w.mem_ready = 1'b1;
   assign bus_w.mem_rdata = 16'h0312;

   always #5 clk = ~clk;

   cpu_ctrl_mc #(.DATA_W(16), .ADDR_W(16), .RESET_PC(16'h0000)) dut (
      .clk(clk), .reset(reset), .mem(bus), .rsrc_val(rsrc_val), .rdest_val(rdest_val),
      .flags(flags), .instr(instr), .mdr(mdr), .rf_we(rf_we), .wb_sel_mem(wb_sel_mem),
      .flags_we(flags_we), .pc(pc), .state(state)
`ifdef CPU_CTRL_HALT_EN
      , .halted(halted)
`endif
   );

   cpu_ctrl_mc #(.DATA_W(16), .ADDR_W(16), .RESET_PC(16'hFFFF)) dut_w (
      .clk(clk), .reset(reset), .mem(bus_w), .rsrc_val(rsrc_val), .rdest_val(rdest_val),
      .flags(flags), .instr(w_instr), .mdr(w_mdr), .rf_we(w_rf_we), .wb_sel_mem(w_wb_sel_mem),
      .flags_we(w_flags_we), .pc(w_pc), .state(w_state)
`ifdef CPU_CTRL_HALT_EN
      , .halted(w_halted)
`endif
   );

   task automatic tick;
      @(negedge clk);
   endtask

   // Present one instruction in the current FETCH cycle with no wait states; returns in DECODE.
   task automatic fetch(input logic [15:0] ins);
      bus.mem_ready = 1'b1;
      bus.mem_rdata = ins;
      tick;
      bus.mem_ready = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      tick;
      tick;
      vectors++; if (state !== 3'd0) begin miscompares++; $display("FAIL rst_state got %0d want 0", state); end
      vectors++; if (pc !== 16'h0000) begin miscompares++; $display("FAIL rst_pc got %h want 0000", pc); end
      vectors++; if (instr !== 16'h0000) begin miscompares++; $display("FAIL rst_instr got %h want 0000", instr); end
      vectors++; if (mdr !== 16'h0000) begin miscompares++; $display("FAIL rst_mdr got %h want 0000", mdr); end
      vectors++; if ({bus.mem_req, rf_we, flags_we, wb_sel_mem} !== 4'b0000) begin miscompares++; $display("FAIL rst_strobes got %b want 0000", {bus.mem_req, rf_we, flags_we, wb_sel_mem}); end
      reset = 1'b1;
      vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL rst_cycle1_req got %b want 0", bus.mem_req); end
      tick;
      vectors++; if (state !== 3'd1) begin miscompares++; $display("FAIL rst_cycle2_state got %0d want 1", state); end
      vectors++; if ({bus.mem_req, bus.mem_we} !== 2'b10) begin miscompares++; $display("FAIL rst_cycle2_req got %b want 10", {bus.mem_req, bus.mem_we}); end
      vectors++; if (bus.mem_addr !== 16'h0000) begin miscompares++; $display("FAIL rst_first_addr got %h want 0000", bus.mem_addr); end
      fetch(16'h0312);
      vectors++; if (state !== 3'd2) begin miscompares++; $display("FAIL rst_decode got %0d want 2", state); end
      vectors++; if (pc !== 16'h0001) begin miscompares++; $display("FAIL rst_pc_inc got %h want 0001", pc); end
      vectors++; if (instr !== 16'h0312) begin miscompares++; $display("FAIL rst_ir got %h want 0312", instr); end
      tick;
      tick;
      vectors++; if (state !== 3'd1) begin miscompares++; $display("FAIL rst_refetch got %0d want 1", state); end
   endtask

   task automatic test_alu;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 16'h0312;
      tick;
      vectors++; if (state !== 3'd1 || bus.mem_req !== 1'b1) begin miscompares++; $display("FAIL alu_wait1 state %0d req %b want 1 1", state, bus.mem_req); end
      vectors++; if (bus.mem_addr !== 16'h0001) begin miscompares++; $display("FAIL alu_wait_addr got %h want 0001", bus.mem_addr); end
      tick;
      vectors++; if (state !== 3'd1) begin miscompares++; $display("FAIL alu_wait2 got %0d want 1", state); end
      fetch(16'h0312);
      vectors++; if (state !== 3'd2 || rf_we !== 1'b0 || flags_we !== 1'b0) begin miscompares++; $display("FAIL alu_decode state %0d rf_we %b flags_we %b want 2 0 0", state, rf_we, flags_we); end
      tick;
      vectors++; if (state !== 3'd3) begin miscompares++; $display("FAIL alu_exec got %0d want 3", state); end
      vectors++; if ({rf_we, flags_we, wb_sel_mem} !== 3'b110) begin miscompares++; $display("FAIL alu_strobes got %b want 110", {rf_we, flags_we, wb_sel_mem}); end
      tick;
      vectors++; if (state !== 3'd1 || {rf_we, flags_we} !== 2'b00) begin miscompares++; $display("FAIL alu_pulse state %0d strobes %b want 1 00", state, {rf_we, flags_we}); end
      vectors++; if (pc !== 16'h0002) begin miscompares++; $display("FAIL alu_pc got %h want 0002", pc); end
      fetch(16'h03B2);
      bus.mem_ready = 1'b1;
      tick;
      bus.mem_ready = 1'b0;
      vectors++; if (state !== 3'd3) begin miscompares++; $display("FAIL cmp_exec got %0d want 3", state); end
      vectors++; if ({rf_we, flags_we} !== 2'b01) begin miscompares++; $display("FAIL cmp_strobes got %b want 01", {rf_we, flags_we}); end
      tick;
      vectors++; if (state !== 3'd1 || pc !== 16'h0003) begin miscompares++; $display("FAIL cmp_done state %0d pc %h want 1 0003", state, pc); end
   endtask

   task automatic test_load;
      rsrc_val = 16'h0040;
      fetch(16'h4102);
      tick;
      vectors++; if (state !== 3'd4 || bus.mem_req !== 1'b1) begin miscompares++; $display("FAIL ld_mem state %0d req %b want 4 1", state, bus.mem_req); end
      vectors++; if (bus.mem_addr !== 16'h0040 || bus.mem_we !== 1'b0) begin miscompares++; $display("FAIL ld_addr addr %h we %b want 0040 0", bus.mem_addr, bus.mem_we); end
      tick;
      vectors++; if (state !== 3'd4 || bus.mem_addr !== 16'h0040 || rf_we !== 1'b0) begin miscompares++; $display("FAIL ld_wait state %0d addr %h rf_we %b want 4 0040 0", state, bus.mem_addr, rf_we); end
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 16'hBEEF;
      tick;
      bus.mem_ready = 1'b0;
      vectors++; if (state !== 3'd5) begin miscompares++; $display("FAIL ld_wb_state got %0d want 5", state); end
      vectors++; if (mdr !== 16'hBEEF) begin miscompares++; $display("FAIL ld_mdr got %h want beef", mdr); end
      vectors++; if ({rf_we, wb_sel_mem, flags_we} !== 3'b110) begin miscompares++; $display("FAIL ld_wb_strobes got %b want 110", {rf_we, wb_sel_mem, flags_we}); end
      vectors++; if (instr !== 16'h4102 || pc !== 16'h0004) begin miscompares++; $display("FAIL ld_ir_pc ir %h pc %h want 4102 0004", instr, pc); end
      tick;
      vectors++; if (state !== 3'd1 || rf_we !== 1'b0 || bus.mem_addr !== 16'h0004) begin miscompares++; $display("FAIL ld_done state %0d rf_we %b addr %h want 1 0 0004", state, rf_we, bus.mem_addr); end
   endtask

   task automatic test_store;
      rsrc_val  = 16'h0080;
      rdest_val = 16'h1234;
      fetch(16'h4142);
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 16'h0000;
      tick;
      vectors++; if (state !== 3'd4 || {bus.mem_req, bus.mem_we} !== 2'b11) begin miscompares++; $display("FAIL st_mem state %0d req_we %b want 4 11", state, {bus.mem_req, bus.mem_we}); end
      vectors++; if (bus.mem_wdata !== 16'h1234 || bus.mem_addr !== 16'h0080) begin miscompares++; $display("FAIL st_bus wdata %h addr %h want 1234 0080", bus.mem_wdata, bus.mem_addr); end
      tick;
      bus.mem_ready = 1'b0;
      vectors++; if (state !== 3'd1 || rf_we !== 1'b0 || bus.mem_we !== 1'b0) begin miscompares++; $display("FAIL st_done state %0d rf_we %b we %b want 1 0 0", state, rf_we, bus.mem_we); end
      vectors++; if (pc !== 16'h0005) begin miscompares++; $display("FAIL st_pc got %h want 0005", pc); end
   endtask

   task automatic test_branch;
      rsrc_val = 16'h0010;
      flags = 5'b00000;
      fetch(16'h4EC3);
      tick;
      vectors++; if (state !== 3'd6) begin miscompares++; $display("FAIL br_state got %0d want 6", state); end
      tick;
      vectors++; if (state !== 3'd1 || bus.mem_addr !== 16'h0010) begin miscompares++; $display("FAIL jmp_0010 state %0d addr %h want 1 0010", state, bus.mem_addr); end
      flags = 5'b01000;
      fetch(16'hC0FE);
      vectors++; if (pc !== 16'h0011) begin miscompares++; $display("FAIL beq_pc_inc got %h want 0011", pc); end
      tick;
      tick;
      vectors++; if (bus.mem_addr !== 16'h000E) begin miscompares++; $display("FAIL beq_taken got %h want 000e", bus.mem_addr); end
      flags = 5'b00000;
      fetch(16'h4EC3);
      tick;
      tick;
      fetch(16'hC0FE);
      tick;
      tick;
      vectors++; if (bus.mem_addr !== 16'h0011) begin miscompares++; $display("FAIL beq_not_taken got %h want 0011", bus.mem_addr); end
      fetch(16'hCA05);
      tick;
      tick;
      vectors++; if (bus.mem_addr !== 16'h0016) begin miscompares++; $display("FAIL blo_taken got %h want 0016", bus.mem_addr); end
      rsrc_val = 16'h0200;
      fetch(16'h4FC3);
      tick;
      tick;
      vectors++; if (bus.mem_addr !== 16'h0017) begin miscompares++; $display("FAIL jnever got %h want 0017", bus.mem_addr); end
      fetch(16'h4EC3);
      tick;
      tick;
      vectors++; if (bus.mem_addr !== 16'h0200) begin miscompares++; $display("FAIL juc_0200 got %h want 0200", bus.mem_addr); end
      flags = 5'b00001;
      fetch(16'hC203);
      tick;
      tick;
      vectors++; if (bus.mem_addr !== 16'h0203 || state !== 3'd1) begin miscompares++; $display("FAIL bcs_taken addr %h state %0d want 0203 1", bus.mem_addr, state); end
      flags = 5'b00000;
   endtask

   task automatic test_ffff;
`ifdef CPU_CTRL_HALT_EN
      int bad;
      fetch(16'hFFFF);
      vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL halt_early got %b want 0", halted); end
      tick;
      vectors++; if (state !== 3'd7 || halted !== 1'b1) begin miscompares++; $display("FAIL halt_enter state %0d halted %b want 7 1", state, halted); end
      bad = 0;
      bus.mem_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         tick;
         if (bus.mem_req !== 1'b0 || rf_we !== 1'b0 || flags_we !== 1'b0 || halted !== 1'b1) bad++;
      end
      bus.mem_ready = 1'b0;
      vectors++; if (bad !== 0) begin miscompares++; $display("FAIL halt_hold bad_cycles got %0d want 0", bad); end
`else
      fetch(16'hFFFF);
      tick;
      vectors++; if (state !== 3'd3 || rf_we !== 1'b1) begin miscompares++; $display("FAIL ffff_alu state %0d rf_we %b want 3 1", state, rf_we); end
      tick;
      vectors++; if (state !== 3'd1 || pc !== 16'h0204) begin miscompares++; $display("FAIL ffff_done state %0d pc %h want 1 0204", state, pc); end
`endif
   endtask

   task automatic test_reset_mid_mem;
      reset = 1'b0;
      tick;
      reset = 1'b1;
      tick;
      rsrc_val = 16'h0040;
      fetch(16'h4102);
      tick;
      vectors++; if (state !== 3'd4 || bus.mem_req !== 1'b1) begin miscompares++; $display("FAIL rmm_in_mem state %0d req %b want 4 1", state, bus.mem_req); end
      #2 reset = 1'b0;
      #1;
      vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL rmm_req_drop got %b want 0", bus.mem_req); end
      vectors++; if (state !== 3'd0 || rf_we !== 1'b0) begin miscompares++; $display("FAIL rmm_idle state %0d rf_we %b want 0 0", state, rf_we); end
      vectors++; if (pc !== 16'h0000 || mdr !== 16'h0000) begin miscompares++; $display("FAIL rmm_regs pc %h mdr %h want 0000 0000", pc, mdr); end
      @(negedge clk);
      reset = 1'b1;
      tick;
      vectors++; if (state !== 3'd1 || bus.mem_addr !== 16'h0000) begin miscompares++; $display("FAIL rmm_restart state %0d addr %h want 1 0000", state, bus.mem_addr); end
   endtask

   task automatic test_pc_wrap;
      reset = 1'b0;
      tick;
      reset = 1'b1;
      vectors++; if (w_state !== 3'd0 || w_pc !== 16'hFFFF) begin miscompares++; $display("FAIL wrap_reset state %0d pc %h want 0 ffff", w_state, w_pc); end
      tick;
      vectors++; if (w_state !== 3'd1 || bus_w.mem_addr !== 16'hFFFF || bus_w.mem_req !== 1'b1) begin miscompares++; $display("FAIL wrap_fetch state %0d addr %h req %b want 1 ffff 1", w_state, bus_w.mem_addr, bus_w.mem_req); end
      vectors++; if ({w_rf_we, w_flags_we, w_wb_sel_mem, bus_w.mem_we} !== 4'b0000 || w_mdr !== 16'h0000) begin miscompares++; $display("FAIL wrap_strobes got %b mdr %h want 0000 0000", {w_rf_we, w_flags_we, w_wb_sel_mem, bus_w.mem_we}, w_mdr); end
      tick;
      vectors++; if (w_pc !== 16'h0000 || w_state !== 3'd2 || w_instr !== 16'h0312) begin miscompares++; $display("FAIL wrap_pc pc %h state %0d ir %h want 0000 2 0312", w_pc, w_state, w_instr); end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 16'h0000;
      rsrc_val = 16'h0000;
      rdest_val = 16'h0000;
      flags = 5'b00000;
      test_reset;
      test_alu;
      test_load;
      test_store;
      test_branch;
      test_ffff;
      test_reset_mid_mem;
      test_pc_wrap;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/cpu_ctrl_mc.md
# cpu_ctrl_mc

Parametrised multicycle control unit for the 16-bit CPU. It replaces the fixed fetch/execute sequencer, program counter and instruction register with one block. The block adds:
- load/store sequencing over a ready-handshaked memory port
- conditional branches and jumps evaluated against the flag register
- variable memory latency

It sits between the BRAM port A, the decoder, the register bank write enable and the flag register.

## Interface
Parameters:
- DATA_W, 16, width of memory data and register values
- ADDR_W, 16, width of PC and memory address
- RESET_PC, 0, PC value loaded at reset

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- mem_req  out  1  memory access request, held until mem_ready
- mem_we  out  1  1 = write (store), 0 = read
- mem_addr  out  ADDR_W  access address
- mem_wdata  out  DATA_W  store data
- mem_ready  in  1  read data valid / write accepted this cycle
- mem_rdata  in  DATA_W  read data
- rsrc_val  in  DATA_W  register-file value selected by ir[3:0]
- rdest_val  in  DATA_W  register-file value selected by ir[11:8]
- flags  in  5  {N,Z,F,L,C} from the flag register
- instr  out  16  instruction register contents, to the decoder
- mdr  out  DATA_W  load data register, to the write-back mux
- rf_we  out  1  register-file write strobe
- wb_sel_mem  out  1  1 = write back mdr, 0 = write back ALU output
- flags_we  out  1  flag-register write strobe
- pc  out  ADDR_W  current PC
- state  out  3  FSM state, for debug
- halted  out  1  core halted; exists only with CPU_CTRL_HALT_EN

## Operation
Encoding:
- opcode = ir[15:12], rdest/cond = ir[11:8], ext = ir[7:4], rsrc = ir[3:0]
- LOAD: op 4, ext 0, Rdest ← mem[Rsrc]
- STOR: op 4, ext 4, mem[Rsrc] ← Rdest
- Jcond: op 4, ext C, PC ← Rsrc
- Bcond: op C, PC ← PC_instr + sext(ir[7:0])
- CMP: op 0, ext B; CMPI: op B. Both are flags-only.
- All other encodings are ALU ops.

Condition codes (cond field):
- 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C
- 4 HI L; 5 LS !L; 6 GT N; 7 LE !N
- 8 FS F; 9 FC !F
- A LO !L&!Z; B HS L|Z; C LT !N&!Z; D GE N|Z
- E UC always; F never

States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, BRANCH=6, HALT=7.
- IDLE: all strobes 0; goes to FETCH next cycle.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc. On mem_ready: instr←mem_rdata, pc←pc+1, go to DECODE. Otherwise stay.
- DECODE: strobes 0. ALU/CMP ops go to EXEC; LOAD/STOR go to MEM; Bcond/Jcond go to BRANCH.
- EXEC: flags_we=1. rf_we=1 unless CMP/CMPI. wb_sel_mem=0. Go to FETCH.
- MEM: mem_req=1, mem_addr=rsrc_val[ADDR_W-1:0], mem_we=1 for STOR, mem_wdata=rdest_val. On mem_ready: LOAD captures mdr←mem_rdata and goes to WB; STOR goes to FETCH.
- WB: rf_we=1, wb_sel_mem=1. Go to FETCH.
- BRANCH: if the condition holds, pc←target. Go to FETCH.
- Branch target for Bcond: (pc−1)+sext(disp8), because pc is already incremented.
- All PC arithmetic wraps modulo 2^ADDR_W. PC FFFF+1 → 0000.
- mem_addr, mem_we and mem_wdata stay stable while mem_req=1 and mem_ready=0.
- mem_ready is ignored when mem_req=0.
- Reset asserted mid-access drops mem_req immediately. The access is abandoned; no rf_we or pc change occurs.

## Timing
- Reset values: state=IDLE, pc=RESET_PC, instr=0, mdr=0, halted=0, all strobes 0.
- First fetch request is in the 2nd cycle after reset deassertion.
- Per-instruction cycle counts, with mem_ready high in the first request cycle:
  - ALU: 3
  - STOR: 3
  - LOAD: 4
  - branch/jump: 3
- Each memory wait cycle adds 1 to the count.
- rf_we and flags_we are single-cycle pulses.
- Register and flag writes take effect on the same edge that leaves EXEC or WB.

## Configuration
- CPU_CTRL_HALT_EN defined:
  - instr 16'hFFFF in DECODE goes to HALT.
  - HALT holds all strobes 0 and sets halted=1 until reset.
- Macro undefined:
  - 16'hFFFF executes as an ALU op.
  - No HALT state is reachable and the halted port is absent.

## Test plan
- Reset release, mem_ready tied 1: mem_req rises in cycle 2 with mem_addr=0000; pc=0001 after the fetch.
- ALU op 16'h0312 with 2 wait states on fetch: FETCH lasts 3 cycles, then DECODE, then EXEC with rf_we=1 and flags_we=1. CMP 16'h03B2 gives rf_we=0 and flags_we=1.
- LOAD 16'h4102, rsrc_val=0x0040, mem_rdata=0xBEEF: mem_addr=0x0040 and mem_we=0 in MEM; mdr=0xBEEF; WB with rf_we=1 and wb_sel_mem=1. STOR 16'h4142, rdest_val=0x1234: mem_we=1 and mem_wdata=0x1234.
- Bcond at address 0x0010, 16'hC0FE (EQ, disp −2): with Z=1, next fetch at 0x000E; with Z=0, next fetch at 0x0011. Jcond UC 16'h4EC3, rsrc_val=0x0200: next fetch at 0x0200.
- PC wrap: RESET_PC=FFFF gives a fetch at FFFF, then pc=0000. Reset pulsed while MEM is waiting gives mem_req=0 immediately, state=IDLE, no rf_we.
- With CPU_CTRL_HALT_EN, fetching 16'hFFFF gives halted=1 and no further mem_req for 100 cycles.
